// File: rtl/next_pc_unit_pkg.sv
// next_pc_unit_pkg: pipeline types shared by the next-PC unit and its target calculator
package next_pc_unit_pkg;

   typedef enum logic [1:0] {TYPE_OTHER, TYPE_B, TYPE_J, TYPE_JALR} OpType;

   typedef enum logic [1:0] {NPC_RUN, NPC_DRAIN, NPC_TRAP} NextPcState;

   localparam logic [31:0] INSN_BYTES = 32'd4;

   function automatic logic isAligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/next_pc_unit_target.sv
// branch_target_calc: redirect target op1+op2 with JALR bit-0 clearing and alignment check
module branch_target_calc
   import next_pc_unit_pkg::*;
(
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        isJalr,
   output logic [31:0] tgt,
   output logic        misaligned
);

   logic [31:0] sum;

   assign sum        = op1 + op2;
   assign tgt        = {sum[31:1], sum[0] & ~isJalr};
   assign misaligned = ~isAligned(tgt);

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: owns the fetch PC, redirects on taken B/J/JALR, drains the front end and traps misaligned targets
module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        exValid,
   input  OpType       exOpType,
   input  logic        exBrTaken,
   input  logic [31:0] irregPcOp1,
   input  logic [31:0] irregPcOp2,
   input  logic        fetchReady,
   input  logic        trapAck,
   output logic        fetchValid,
   output logic [31:0] fetchPc,
   output logic        flush,
   output logic        trapValid,
   output logic [31:0] trapTval
);

   NextPcState  state, stateNext;
   logic [31:0] pc, pcNext, tvalNext, tgt;
   logic [2:0]  cnt, cntNext;
   logic        misaligned, isCtrl, redirect;

   branch_target_calc targetCalc (
      .op1       (irregPcOp1),
      .op2       (irregPcOp2),
      .isJalr    (exOpType == TYPE_JALR),
      .tgt       (tgt),
      .misaligned(misaligned)
   );

   assign isCtrl   = exOpType == TYPE_J || exOpType == TYPE_JALR || (exOpType == TYPE_B && exBrTaken);
   assign redirect = rstN && state == NPC_RUN && exValid && isCtrl;
   assign fetchPc  = pc;

   // Redirect outranks the fetch handshake, so a same-cycle pc+4 is dropped.
   always_comb begin
      stateNext  = state;
      pcNext     = pc;
      cntNext    = cnt;
      tvalNext   = trapTval;
      fetchValid = 1'b0;
      flush      = 1'b0;
      trapValid  = 1'b0;
      case (state)
         NPC_RUN: begin
            fetchValid = rstN;
            flush      = redirect;
            if (redirect && !misaligned) begin
               pcNext    = tgt;
               cntNext   = 3'(FLUSH_CYCLES);
               stateNext = NPC_DRAIN;
            end else if (redirect) begin
               tvalNext  = tgt;
               stateNext = NPC_TRAP;
            end else if (fetchReady) begin
               pcNext = pc + INSN_BYTES;
            end
         end
         NPC_DRAIN: begin
            cntNext   = cnt - 3'd1;
            stateNext = cnt <= 3'd1 ? NPC_RUN : NPC_DRAIN;
         end
         NPC_TRAP: begin
            trapValid = rstN;
            pcNext    = trapAck ? TRAP_VEC : pc;
            stateNext = trapAck ? NPC_RUN : NPC_TRAP;
         end
         default: stateNext = NPC_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state    <= NPC_RUN;
         pc       <= RESET_PC;
         cnt      <= 3'd0;
         trapTval <= 32'd0;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         cnt      <= cntNext;
         trapTval <= tvalNext;
      end
   end

endmodule
